vector_div_arbiter: RTL

Shares the single iterative vector divide unit between the vector lanes. Each lane issues a divide request and waits for its result. Round-robin arbitration picks one request at a time. The block latches the winner's operands, pulses the divider start, waits for done (with a watchdog), and returns the result to the owning lane over a valid/ready handshake. It sits between the lane issue logic and the divide unit's start/done interface.

---
 rtl/rv32v_types_pkg.sv | 14 +
 rtl/vector_div_arbiter_rr_arbiter.sv | 29 ++
 rtl/vector_div_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector divide arbiter: FSM state encoding and watchdog width.
package rv32v_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } divarb_state_t;

    localparam int unsigned DIVARB_WDOG_W = 16;

endpackage

// File: rtl/vector_div_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one lane past ptr_i and wraps.
module rr_arbiter #(
    parameter int unsigned NLANES = 2,
    parameter int unsigned PTR_W  = 1
) (
    input  logic [NLANES-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NLANES-1:0] gnt_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 1; off <= NLANES; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= NLANES) begin
                idx = idx - NLANES;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_div_arbiter.sv
// Shares one iterative divide unit between NLANES vector lanes: round-robin grant,
// operand latch, start/done handshake with watchdog, valid/ready result return.
module vector_div_arbiter
    import rv32v_types_pkg::*;
#(
    parameter int unsigned NLANES      = 2,
    parameter int unsigned DW          = 32,
    parameter int unsigned WDOG_CYCLES = 40
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic [NLANES-1:0]    req,
    input  logic [NLANES*DW-1:0] vs1_data,
    input  logic [NLANES*DW-1:0] vs2_data,
    input  logic [NLANES-1:0]    div_type,
    input  logic [NLANES-1:0]    is_signed_div,
    output logic [NLANES-1:0]    gnt,
    output logic [NLANES-1:0]    lane_busy,
    output logic [NLANES-1:0]    resp_valid,
    input  logic [NLANES-1:0]    resp_ready,
    output logic [DW-1:0]        resp_data,
    output logic                 resp_exception,
    output logic                 du_start,
    output logic [DW-1:0]        du_vs1,
    output logic [DW-1:0]        du_vs2,
    output logic                 du_div_type,
    output logic                 du_is_signed,
    input  logic                 du_done,
    input  logic [DW-1:0]        du_wdata,
    input  logic                 du_exception
);

    localparam int unsigned PTR_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [DIVARB_WDOG_W-1:0] WDOG_LAST = DIVARB_WDOG_W'(WDOG_CYCLES - 1);

    divarb_state_t            state_q;
    logic [PTR_W-1:0]         rr_ptr_q;
    logic [PTR_W-1:0]         owner_q;
    logic [DIVARB_WDOG_W-1:0] wdog_q;
    logic [DIVARB_WDOG_W-1:0] wdog_d;
    logic [NLANES-1:0]        lane_busy_q;
    logic [NLANES-1:0]        resp_valid_q;
    logic [DW-1:0]            resp_data_q;
    logic                     resp_exc_q;
    logic [DW-1:0]            vs1_q;
    logic [DW-1:0]            vs2_q;
    logic                     div_type_q;
    logic                     is_signed_q;

    logic [NLANES-1:0]        arb_gnt;
    logic [PTR_W-1:0]         win_idx;
    logic                     wdog_expired;

    rr_arbiter #(
        .NLANES (NLANES),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req_i  (req),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (arb_gnt)
    );

    // Grant and start are the only combinational outputs; both yield to flush and reset.
    always_comb begin
        gnt      = (state_q == IDLE && !flush && !RST) ? arb_gnt : '0;
        du_start = (state_q == ISSUE) && !flush && !RST;
        win_idx  = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (arb_gnt[i]) begin
                win_idx = PTR_W'(i);
            end
        end
        wdog_d       = wdog_q + 1'b1;
        wdog_expired = (wdog_q == WDOG_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            rr_ptr_q     <= PTR_W'(NLANES - 1);
            owner_q      <= '0;
            wdog_q       <= '0;
            lane_busy_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_exc_q   <= 1'b0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            div_type_q   <= 1'b0;
            is_signed_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!flush && (|arb_gnt)) begin
                        owner_q     <= win_idx;
                        vs1_q       <= vs1_data[win_idx*DW +: DW];
                        vs2_q       <= vs2_data[win_idx*DW +: DW];
                        div_type_q  <= div_type[win_idx];
                        is_signed_q <= is_signed_div[win_idx];
                        lane_busy_q <= arb_gnt;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        lane_busy_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        wdog_q  <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        // The divider is still running; DRAIN absorbs its done pulse.
                        lane_busy_q <= '0;
                        wdog_q      <= wdog_d;
                        state_q     <= DRAIN;
                    end else if (du_done) begin
                        resp_data_q  <= du_wdata;
                        resp_exc_q   <= du_exception;
                        resp_valid_q <= lane_busy_q;
                        state_q      <= RESP;
                    end else if (wdog_expired) begin
                        resp_data_q  <= '0;
                        resp_exc_q   <= 1'b1;
                        resp_valid_q <= lane_busy_q;
                        state_q      <= RESP;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                RESP: begin
                    if (flush) begin
                        resp_valid_q <= '0;
                        lane_busy_q  <= '0;
                        state_q      <= IDLE;
                    end else if (resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        lane_busy_q  <= '0;
                        rr_ptr_q     <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (du_done || wdog_expired) begin
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lane_busy      = lane_busy_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_exception = resp_exc_q;
    assign du_vs1         = vs1_q;
    assign du_vs2         = vs2_q;
    assign du_div_type    = div_type_q;
    assign du_is_signed   = is_signed_q;

endmodule
